// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serialiser between NUM_REQ byte producers.
// Optional feature macro: UART_TX_ARB_LOCK_EN keeps multi-byte messages contiguous.
module uart_tx_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter logic [15:0] DEFAULT_WAIT = 16'd103,
  parameter int          BUSY_TIMEOUT = 4
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [NUM_REQ-1:0]                                 req_valid,
  input  logic [8*NUM_REQ-1:0]                               req_data,
  input  logic [NUM_REQ-1:0]                                 req_last,
  output logic [NUM_REQ-1:0]                                 req_ready,
  input  logic [15:0]                                        cfg_wait_cycles,
  output logic [7:0]                                         uart_data,
  output logic                                               uart_start,
  input  logic                                               uart_busy,
  output logic [15:0]                                        uart_wait_cycles,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]   grant_id,
  output logic                                               active,
  output logic                                               err_timeout
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t              state_r;
  logic [TW-1:0]       timer_r;
  logic [NUM_REQ-1:0]  eligible_s;
  logic                found_s;
  logic [GW-1:0]       winner_s;
  logic [7:0]          win_data_s;
  logic                win_last_s;

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_r;

  // While locked, only the requester that opened the message may be granted.
  always_comb begin
    eligible_s = '0;
    if (lock_r) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        eligible_s[i] = req_valid[i] & (GW'(i) == grant_id);
      end
    end else begin
      eligible_s = req_valid;
    end
  end
`else
  logic unused_last_s;
  assign unused_last_s = ^{req_last, win_last_s};

  // Every valid requester competes for each byte.
  always_comb begin
    eligible_s = req_valid;
  end
`endif

  // Round-robin search: indices above the last grant first, then wrap to 0..grant_id.
  always_comb begin
    found_s    = 1'b0;
    winner_s   = '0;
    win_data_s = 8'd0;
    win_last_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && eligible_s[i] && (GW'(i) > grant_id)) begin
        found_s    = 1'b1;
        winner_s   = GW'(i);
        win_data_s = req_data[8*i +: 8];
        win_last_s = req_last[i];
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && eligible_s[i] && (GW'(i) <= grant_id)) begin
        found_s    = 1'b1;
        winner_s   = GW'(i);
        win_data_s = req_data[8*i +: 8];
        win_last_s = req_last[i];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Accept strobe is combinational so the byte transfers in the same IDLE cycle.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_r == IDLE) && found_s) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (GW'(i) == winner_s);
      end
    end else begin
      req_ready = '0;
    end
  end

  // Frame sequencer with registered uart-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      timer_r          <= '0;
      uart_data        <= 8'd0;
      uart_start       <= 1'b0;
      uart_wait_cycles <= DEFAULT_WAIT;
      grant_id         <= GW'(NUM_REQ - 1);
      active           <= 1'b0;
      err_timeout      <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_r           <= 1'b0;
`endif
    end else begin
      uart_start  <= 1'b0;
      err_timeout <= 1'b0;
      case (state_r)
        IDLE: begin
          uart_wait_cycles <= cfg_wait_cycles;
          if (found_s) begin
            uart_data  <= win_data_s;
            grant_id   <= winner_s;
            uart_start <= 1'b1;
            active     <= 1'b1;
            state_r    <= ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
            lock_r     <= ~win_last_s;
`endif
          end else begin
            active  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          timer_r <= '0;
          state_r <= WAIT_HI;
        end
        WAIT_HI: begin
          if (uart_busy) begin
            state_r <= WAIT_LO;
          end else if (timer_r == TW'(BUSY_TIMEOUT - 1)) begin
            // Serialiser never acknowledged the start: drop the byte.
            err_timeout <= 1'b1;
            active      <= 1'b0;
            state_r     <= IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            lock_r      <= 1'b0;
`endif
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        WAIT_LO: begin
          if (!uart_busy) begin
            active  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_LO;
          end
        end
        default: begin
          active  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester drivers, a uart_tx busy model and a byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] id;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [15:0]     cfg_wait_cycles;
  logic [7:0]      uart_data;
  logic            uart_start;
  logic            uart_busy;
  logic [15:0]     uart_wait_cycles;
  logic [1:0]      grant_id;
  logic            active;
  logic            err_timeout;

  int   vectors;
  int   miscompares;
  int   start_cnt;
  bit   no_busy;
  exp_t sb [$];
  logic [8:0] src_q [NR][$];

  uart_tx_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .cfg_wait_cycles  (cfg_wait_cycles),
    .uart_data        (uart_data),
    .uart_start       (uart_start),
    .uart_busy        (uart_busy),
    .uart_wait_cycles (uart_wait_cycles),
    .grant_id         (grant_id),
    .active           (active),
    .err_timeout      (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic send(input int r, input logic [7:0] d, input logic last, input bit expect_now);
    src_q[r].push_back({last, d});
    if (expect_now) sb.push_back('{d: d, id: 8'(r)});
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (uart_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 40), 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !(src_empty() && sb.size() == 0 && active === 1'b0 && uart_busy === 1'b0)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  // Requester drivers: present queue heads, retire a byte after its accept strobe.
  initial begin
    logic [NR-1:0] rdy;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (rdy[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = src_q[i][0][7:0];
          req_last[i]         = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // uart_tx model: checks each started byte, then holds busy for a 10-bit frame.
  initial begin
    exp_t e;
    int   len;
    uart_busy = 1'b0;
    start_cnt = 0;
    forever begin
      @(negedge clk);
      if (req_ready !== '0) begin
        check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        check("ready_only_idle", 32'(active), 32'd0);
      end
      if (rst_n === 1'b1 && uart_start === 1'b1) begin
        start_cnt++;
        e = 'x;
        if (sb.size() > 0) e = sb.pop_front();
        check("line_data", 32'(uart_data), 32'(e.d));
        check("line_id", 32'(grant_id), 32'(e.id));
        if (!no_busy) begin
          len = 10 * (int'(uart_wait_cycles) + 1);
          for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            if (rst_n !== 1'b1) break;
            uart_busy = 1'b1;
          end
          uart_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    int s0;
    int n;
    vectors     = 0;
    miscompares = 0;
    no_busy     = 1'b0;
    rst_n       = 1'b0;
    cfg_wait_cycles = 16'd7;

    // Reset values, independent of cfg_wait_cycles.
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(uart_start), 32'd0);
    check("rst_data", 32'(uart_data), 32'd0);
    check("rst_wait", 32'(uart_wait_cycles), 32'd103);
    check("rst_gid", 32'(grant_id), 32'd3);
    check("rst_active", 32'(active), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    cfg_wait_cycles = 16'd103;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rel_wait", 32'(uart_wait_cycles), 32'd103);
    cfg_wait_cycles = 16'd3;
    repeat (2) @(negedge clk);
    check("idle_tracks_cfg", 32'(uart_wait_cycles), 32'd3);

    // Round-robin: all four valid, three bytes each, grant order 0,1,2,3 repeated.
    s0 = start_cnt;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NR; i++) send(i, 8'(16 * i + r + 1), 1'b1, 1'b1);
    end
    wait_drain("rr_drain", 3000);
    check("rr_start_count", 32'(start_cnt - s0), 32'd12);

    // Single requester 2: same-cycle ready, start one cycle later.
    send(2, 8'h55, 1'b1, 1'b1);
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    check("single_start", 32'(uart_start), 32'd1);
    check("single_data", 32'(uart_data), 32'h55);
    check("single_gid", 32'(grant_id), 32'd2);
    @(negedge clk);
    check("single_start_pulse", 32'(uart_start), 32'd0);
    wait_drain("single_drain", 500);

    // Busy never rises: timeout pulse after four WAIT_HI cycles, then normal service.
    no_busy = 1'b1;
    send(1, 8'hA1, 1'b1, 1'b1);
    wait_start("to_start");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (err_timeout !== 1'b1 && n < 12);
    check("to_pulse_delay", 32'(n), 32'd5);
    check("to_idle", 32'(active), 32'd0);
    @(negedge clk);
    check("to_pulse_width", 32'(err_timeout), 32'd0);
    no_busy = 1'b0;
    send(2, 8'hB2, 1'b1, 1'b1);
    wait_drain("to_recover", 500);

    // Divider change mid-frame only takes effect once back in IDLE.
    cfg_wait_cycles = 16'd103;
    repeat (2) @(negedge clk);
    check("cfg_pre", 32'(uart_wait_cycles), 32'd103);
    send(3, 8'hC3, 1'b1, 1'b1);
    wait_start("cfg_start");
    repeat (4) @(negedge clk);
    cfg_wait_cycles = 16'd51;
    repeat (4) @(negedge clk);
    check("cfg_hold_active", 32'(active), 32'd1);
    check("cfg_hold_wait", 32'(uart_wait_cycles), 32'd103);
    n = 0;
    while (active !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("cfg_frame_end", 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk);
    check("cfg_post", 32'(uart_wait_cycles), 32'd51);
    wait_drain("cfg_drain", 500);
    cfg_wait_cycles = 16'd3;
    repeat (2) @(negedge clk);

    // Two-byte message from requester 0 competing with requester 1.
    send(0, 8'h41, 1'b0, 1'b0);
    send(0, 8'h42, 1'b1, 1'b0);
    send(1, 8'h43, 1'b1, 1'b0);
    sb.push_back('{d: 8'h41, id: 8'd0});
`ifdef UART_TX_ARB_LOCK_EN
    sb.push_back('{d: 8'h42, id: 8'd0});
    sb.push_back('{d: 8'h43, id: 8'd1});
`else
    sb.push_back('{d: 8'h43, id: 8'd1});
    sb.push_back('{d: 8'h42, id: 8'd0});
`endif
    wait_drain("msg_drain", 1000);

    // Asynchronous reset in the middle of WAIT_LO.
    send(0, 8'h5A, 1'b1, 1'b1);
    wait_start("mid_start");
    repeat (6) @(negedge clk);
    check("mid_active", 32'(active), 32'd1);
    cfg_wait_cycles = 16'd103;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_start", 32'(uart_start), 32'd0);
    check("mid_rst_data", 32'(uart_data), 32'd0);
    check("mid_rst_wait", 32'(uart_wait_cycles), 32'd103);
    check("mid_rst_gid", 32'(grant_id), 32'd3);
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_err", 32'(err_timeout), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rel_wait", 32'(uart_wait_cycles), 32'd103);
    check("mid_rel_active", 32'(active), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
